// File: rtl/servo_slew_scheduler.sv
// servo_slew_scheduler
// Rate-limited motion scheduler for the servo PWM channels. A free-running
// prescaler produces a slew tick. On a tick (when enabled) one scan walks the
// servos round-robin through a single shared slew unit. Each visit moves that
// servo's current duty toward its clamped target by at most STEP.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high reset
//   enable     new scans start only while high
//   target     commanded duties, servo i at [7i+6:7i]
//   duty       current (registered) duties, same packing
//   at_target  bit i: duty i equalled clamped target i at its last visit
//   busy       high while a scan is in progress
//   tick       one-cycle pulse at prescaler terminal count
module servo_slew_scheduler #(
  parameter int unsigned NUM_SERVO  = 5,
  parameter int unsigned TICK_DIV   = 5000000,
  parameter int unsigned STEP       = 1,
  parameter int unsigned DUTY_MAX   = 99,
  parameter int unsigned RESET_DUTY = 50
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [7*NUM_SERVO-1:0] target,
  output logic [7*NUM_SERVO-1:0] duty,
  output logic [NUM_SERVO-1:0]   at_target,
  output logic                   busy,
  output logic                   tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_SERVO > 1) ? $clog2(NUM_SERVO) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SERVO - 1);
  localparam logic [7:0]       STEP8    = 8'(STEP);
  localparam logic [7:0]       MAX8     = 8'(DUTY_MAX);
  localparam logic [6:0]       RST7     = 7'(RESET_DUTY);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       duty_r [NUM_SERVO];
  logic             visit;

  logic [6:0] tgt_sel;
  logic [6:0] duty_sel;
  logic [7:0] t8;
  logic [7:0] d8;
  logic [7:0] gap8;
  logic [7:0] mv8;
  logic [7:0] dn8;

  // Prescaler: free-running, independent of enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

  // Scan FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state. A tick seen while scanning is dropped, never queued.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    visit     = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN: begin
        visit = 1'b1;
        if (idx == IDX_LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == SCAN);

  // Select the servo being visited; its target is sampled only here.
  always_comb begin
    tgt_sel  = '0;
    duty_sel = '0;
    for (int unsigned i = 0; i < NUM_SERVO; i++) begin
      if (idx == IDX_W'(i)) begin
        tgt_sel  = target[7*i +: 7];
        duty_sel = duty_r[i];
      end
    end
  end

  // Shared slew unit, 8-bit unsigned: the move is the smaller of STEP and
  // the remaining gap, so the result can never overshoot the clamped target.
  always_comb begin
    t8   = ({1'b0, tgt_sel} > MAX8) ? MAX8 : {1'b0, tgt_sel};
    d8   = {1'b0, duty_sel};
    gap8 = '0;
    mv8  = '0;
    dn8  = d8;
    if (d8 < t8) begin
      gap8 = t8 - d8;
      mv8  = (gap8 < STEP8) ? gap8 : STEP8;
      dn8  = d8 + mv8;
    end else if (d8 > t8) begin
      gap8 = d8 - t8;
      mv8  = (gap8 < STEP8) ? gap8 : STEP8;
      dn8  = d8 - mv8;
    end
  end

  // Per-servo duty and at_target registers, written on that servo's visit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SERVO; i++) begin
        duty_r[i] <= RST7;
      end
      at_target <= '0;
    end else if (visit) begin
      for (int unsigned i = 0; i < NUM_SERVO; i++) begin
        if (idx == IDX_W'(i)) begin
          duty_r[i]    <= dn8[6:0];
          at_target[i] <= (dn8 == t8);
        end
      end
    end
  end

  always_comb begin
    duty = '0;
    for (int unsigned i = 0; i < NUM_SERVO; i++) begin
      duty[7*i +: 7] = duty_r[i];
    end
  end

endmodule

// File: doc/servo_slew_scheduler.md
# servo_slew_scheduler

Rate-limited motion scheduler between the register-file servo duty outputs and the five PWM serializers. It holds one current duty per servo. On every prescaled tick it walks the servos round-robin through a single shared slew unit, moving each current duty toward its commanded target by at most STEP. Processor writes therefore become smooth ramps rather than instantaneous jumps.

## Interface
Parameters:
- NUM_SERVO, 5, number of servo channels.
- TICK_DIV, 5000000, clock cycles per slew tick (20 Hz at 100 MHz). Must be ≥ NUM_SERVO+1.
- STEP, 1, maximum duty change per servo per tick (1..99).
- DUTY_MAX, 99, upper clamp for targets and duties.
- RESET_DUTY, 50, value every current duty takes on reset (≤ DUTY_MAX).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scans start only while high.
- target  in  7*NUM_SERVO  commanded duties, servo i at bits [7i+6:7i], unsigned.
- duty  out  7*NUM_SERVO  current duties to the PWM serializers, same packing, registered.
- at_target  out  NUM_SERVO  bit i high when duty i equals the clamped target i as of its last visit.
- busy  out  1  high while a scan is in progress.
- tick  out  1  one-cycle pulse at the prescaler terminal count.

## Operation
- Prescaler: counter 0..TICK_DIV-1, free-running regardless of enable. tick=1 for the cycle in which count==TICK_DIV-1; the counter then wraps to 0.
- FSM states:
  - IDLE: leaves on tick && enable, going to SCAN with idx=0. Otherwise stays in IDLE.
  - SCAN: visits one servo per cycle, idx 0..NUM_SERVO-1. After the idx==NUM_SERVO-1 cycle it returns to IDLE.
- Visit of servo i, one cycle, shared datapath:
  - t = min(target_i, DUTY_MAX).
  - d = duty_i.
  - If d<t, then d' = d + min(STEP, t-d).
  - If d>t, then d' = d - min(STEP, d-t).
  - Otherwise d' = d.
  - Register d' into duty_i. Set at_target[i] = (d'==t).
- Arithmetic: compare and subtract at 8 bits unsigned; no overflow or underflow is possible. A result never overshoots t and never leaves 0..DUTY_MAX.
- Target sampling: target_i is sampled in servo i's visit cycle only. Changes at other times take effect on the next visit.
- enable deasserted mid-scan: the scan completes all channels. No new scan starts while enable is low; duty holds its value.
- A tick arriving while in SCAN cannot occur, given the TICK_DIV constraint. If it does occur, it is ignored and not queued.
- Servos not yet visited in the current scan keep their previous duty.

## Timing
- Reset (asynchronous, immediate):
  - every duty_i = RESET_DUTY; at_target = 0; busy = 0; tick = 0.
  - FSM = IDLE; idx = 0; prescaler = 0.
- First tick occurs TICK_DIV cycles after reset release: the cycle where count==TICK_DIV-1.
- Tick in cycle T with enable=1:
  - busy is high in cycles T+1 .. T+NUM_SERVO.
  - duty_i and at_target[i] are updated at the clock edge ending cycle T+1+i, and are visible from cycle T+2+i.
- Latency from a target change to the first duty movement: at most TICK_DIV+NUM_SERVO+1 cycles.
- Full slew from duty a to target b takes ceil(|b-a|/STEP) ticks.
- Reset asserted mid-scan aborts the scan and applies the reset values immediately. Partial updates are discarded.

## Test plan
- Reset values: TICK_DIV=8. Hold reset for 3 cycles, then release. Required:
  - every duty = 50, at_target = 0, busy = 0.
  - first tick exactly 8 cycles after release.
- Ramp up: STEP=1, TICK_DIV=8, all targets 53, enable=1. Required:
  - duty_0 goes 51, 52, 53 on successive ticks, updating one cycle after each tick; duty_4 updates 4 cycles after duty_0.
  - at_target = 5'b11111 after the third scan.
  - busy is high for exactly 5 cycles per tick.
- Clamp and partial step: STEP=3.
  - target_1=120 from 97: duty_1 becomes 99 after one tick and stays there.
  - target_2=48 from 50: duty_2 becomes 48, not 47.
- Enable gating: enable=0 across 4 ticks with targets ≠ duty. Required:
  - duty unchanged, busy never asserts, tick still pulses every TICK_DIV cycles.
- Enable dropped mid-scan: deassert enable in cycle T+2. Required:
  - servos 2..4 are still updated in the same scan.
  - no scan starts on the next tick.
- Reset mid-scan: assert reset in cycle T+3, during servo 2's visit. Required:
  - all duty values = 50 in the same cycle, busy = 0.
  - after release, the scan restarts from servo 0 on the next tick.
